// File: rtl/mlab_sr_pkg.sv
// Shared constants for the MLAB shift-register front-end.
// Holds geometry, pipeline latency and FSM state codes.
package mlab_sr_pkg;

   localparam int DATA_WIDTH_DEF = 19;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int WORD_WIDTH     = DATA_WIDTH_DEF + 1;
   localparam int DEPTH          = 1 << ADDR_WIDTH_DEF;
   localparam int PIPE_LAT       = 5;
   localparam int MIN_DELAY      = 2;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/mlab_sr_err_track.sv
// Sticky parity-error flag and saturating error counter.
// A counted error takes priority over a same-cycle clear.
module mlab_sr_err_track
   import mlab_sr_pkg::*;
#(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 ena,
   input  logic                 hit,
   input  logic                 clear,
   output logic                 sticky,
   output logic [CNT_WIDTH-1:0] count
);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sticky <= 1'b0;
         count  <= '0;
      end else if (ena) begin
         if (hit) begin
            sticky <= 1'b1;
            if (clear)
               count <= CNT_WIDTH'(1);
            else if (count != '1)
               count <= count + 1'b1;
         end else if (clear) begin
            sticky <= 1'b0;
            count  <= '0;
         end
      end
   end

endmodule

// File: rtl/mlab_sr_driver.sv
// Front-end for the 20x32 MLAB shift-register array: parity insertion,
// circular delay-line addressing, output alignment and error tracking.
module mlab_sr_driver
   import mlab_sr_pkg::*;
#(
   parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
   parameter int DEFAULT_DELAY = 16,
   parameter int CNT_WIDTH     = 8
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  ena,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic [ADDR_WIDTH-1:0] delay,
   input  logic                  delay_load,
   input  logic                  err_clear,
   output logic [DATA_WIDTH:0]   sr_din,
   output logic                  sr_we,
   output logic [ADDR_WIDTH-1:0] sr_wraddr,
   output logic [ADDR_WIDTH-1:0] sr_rdaddr,
   output logic                  sr_parity_in,
   input  logic [DATA_WIDTH:0]   sr_dout,
   input  logic                  sr_parity_err,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   output logic                  dout_perr,
   output logic                  err_sticky,
   output logic [CNT_WIDTH-1:0]  err_count
);

   localparam int CW = ADDR_WIDTH + 1;

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] d_reg;
   logic [ADDR_WIDTH-1:0] d_new;
   logic [ADDR_WIDTH-1:0] d_eff;
   logic [CW-1:0]         fill_cnt;
   logic [CW-1:0]         fill_tgt;
   logic                  adv;
   logic [DATA_WIDTH-1:0] d1;
   logic [DATA_WIDTH-1:0] d2;
   logic                  p2;
   logic                  unused_par;

   // A delay load while idle is a pure configuration cycle.
   assign adv = ena && !((state == ST_IDLE) && delay_load);

   assign d_new = (delay < ADDR_WIDTH'(MIN_DELAY)) ?
                  ADDR_WIDTH'(MIN_DELAY) : delay;
   assign d_eff = delay_load ? d_new : d_reg;
   assign fill_tgt = CW'(d_reg) + CW'(PIPE_LAT);

   assign sr_parity_in = 1'b0;
   assign unused_par   = sr_dout[DATA_WIDTH];

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         sr_din    <= '0;
         sr_we     <= 1'b0;
         sr_wraddr <= '0;
         sr_rdaddr <= '0;
         wr_ptr    <= '0;
         d1        <= '0;
         d2        <= '0;
         p2        <= 1'b0;
         dout      <= '0;
         dout_perr <= 1'b0;
      end else if (adv) begin
         sr_din    <= {~^din, din};
         sr_we     <= 1'b1;
         sr_wraddr <= wr_ptr;
         sr_rdaddr <= wr_ptr - d_eff;
         wr_ptr    <= wr_ptr + 1'b1;
         d1        <= sr_dout[DATA_WIDTH-1:0];
         d2        <= d1;
         p2        <= sr_parity_err;
         dout      <= d2;
         dout_perr <= p2;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state      <= ST_IDLE;
         d_reg      <= ADDR_WIDTH'(DEFAULT_DELAY);
         fill_cnt   <= '0;
         dout_valid <= 1'b0;
      end else if (ena) begin
         if (delay_load)
            d_reg <= d_new;
         case (state)
            ST_IDLE: begin
               if (!delay_load) begin
                  state    <= ST_FILL;
                  fill_cnt <= CW'(1);
               end
            end
            ST_FILL: begin
               if (delay_load) begin
                  fill_cnt <= '0;
               end else if (fill_cnt + 1'b1 == fill_tgt) begin
                  dout_valid <= 1'b1;
                  state      <= ST_RUN;
               end else begin
                  fill_cnt <= fill_cnt + 1'b1;
               end
            end
            ST_RUN: begin
               if (delay_load) begin
                  state      <= ST_FILL;
                  fill_cnt   <= '0;
                  dout_valid <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   mlab_sr_err_track #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_err (
      .clk   (clk),
      .arst  (arst),
      .ena   (ena),
      .hit   (dout_valid && dout_perr),
      .clear (err_clear),
      .sticky(err_sticky),
      .count (err_count)
   );

endmodule

// File: tb/tb_mlab_sr_driver.sv
// Directed bench for mlab_sr_driver with a behavioural MLAB array model.
// Array flags even parity one cycle after its registered data output.
module tb_mlab_sr_driver;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic        ena = 1'b0;
   logic [18:0] din = '0;
   logic [4:0]  delay = '0;
   logic        delay_load = 1'b0;
   logic        err_clear = 1'b0;
   logic [19:0] sr_din;
   logic        sr_we;
   logic [4:0]  sr_wraddr;
   logic [4:0]  sr_rdaddr;
   logic        sr_parity_in;
   logic [19:0] sr_dout;
   logic        sr_parity_err;
   logic [18:0] dout;
   logic        dout_valid;
   logic        dout_perr;
   logic        err_sticky;
   logic [7:0]  err_count;

   int errs = 0;
   int checks = 0;
   int n = 0;
   logic [18:0] hist [0:1023];

   logic [19:0] mem [0:31];
   logic [19:0] arr_q = '0;
   logic        arr_perr = 1'b0;
   logic        inj = 1'b0;
   logic        poison = 1'b0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ena) begin
         if (poison) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
         end else if (sr_we) begin
            mem[sr_wraddr] <= sr_din;
         end
         arr_q    <= mem[sr_rdaddr];
         arr_perr <= ~^sr_dout;
      end
   end

   assign sr_dout = arr_q ^ (inj ? 20'h00080 : 20'h00000);
   assign sr_parity_err = arr_perr;

   mlab_sr_driver dut (
      .clk          (clk),
      .arst         (arst),
      .ena          (ena),
      .din          (din),
      .delay        (delay),
      .delay_load   (delay_load),
      .err_clear    (err_clear),
      .sr_din       (sr_din),
      .sr_we        (sr_we),
      .sr_wraddr    (sr_wraddr),
      .sr_rdaddr    (sr_rdaddr),
      .sr_parity_in (sr_parity_in),
      .sr_dout      (sr_dout),
      .sr_parity_err(sr_parity_err),
      .dout         (dout),
      .dout_valid   (dout_valid),
      .dout_perr    (dout_perr),
      .err_sticky   (err_sticky),
      .err_count    (err_count)
   );

   task automatic adv(input logic ld, input logic [4:0] dly);
      din = 19'(n);
      ena = 1'b1;
      delay_load = ld;
      delay = dly;
      @(posedge clk);
      #1;
      hist[n] = din;
      n++;
      delay_load = 1'b0;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      ena = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({sr_din, sr_we, sr_wraddr, sr_rdaddr, sr_parity_in} !== 32'h0) begin
         errs++;
         $display("FAIL reset_sr: got %0h want 0",
                  {sr_din, sr_we, sr_wraddr, sr_rdaddr, sr_parity_in});
      end
      checks++;
      if ({dout, dout_valid, dout_perr, err_sticky, err_count} !== 30'h0) begin
         errs++;
         $display("FAIL reset_out: got %0h want 0",
                  {dout, dout_valid, dout_perr, err_sticky, err_count});
      end
      arst = 1'b0;
      n = 0;
      @(posedge clk);
      #1;
      checks++;
      if (sr_we !== 1'b0 || sr_din !== 20'h0) begin
         errs++;
         $display("FAIL hold_no_ena: we=%b din=%0h want 0 0", sr_we, sr_din);
      end
   endtask

   task automatic test_fill();
      logic [19:0] exp_w;
      for (int k = 1; k <= 60; k++) begin
         adv(1'b0, 5'd0);
         exp_w = {~^hist[k-1], hist[k-1]};
         checks++;
         if (sr_din !== exp_w || sr_we !== 1'b1) begin
            errs++;
            $display("FAIL fill_sr_din k=%0d: got %0h/%b want %0h/1",
                     k, sr_din, sr_we, exp_w);
         end
         checks++;
         if (sr_wraddr !== 5'(k - 1) || sr_rdaddr !== 5'(k - 17)) begin
            errs++;
            $display("FAIL fill_addr k=%0d: got %0d/%0d want %0d/%0d",
                     k, sr_wraddr, sr_rdaddr, 5'(k - 1), 5'(k - 17));
         end
         if (k == 20) begin
            checks++;
            if (dout_valid !== 1'b0) begin
               errs++;
               $display("FAIL fill_early: valid=%b want 0", dout_valid);
            end
         end
         if (k >= 21) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== hist[k-21] || dout_perr !== 1'b0) begin
               errs++;
               $display("FAIL fill_data k=%0d: got %b/%0h/%b want 1/%0h/0",
                        k, dout_valid, dout, dout_perr, hist[k-21]);
            end
         end
      end
      checks++;
      if (err_count !== 8'd0 || err_sticky !== 1'b0) begin
         errs++;
         $display("FAIL fill_noerr: got %0d/%b want 0/0", err_count, err_sticky);
      end
   endtask

   task automatic test_reload();
      adv(1'b1, 5'd0);
      checks++;
      if (dout_valid !== 1'b0) begin
         errs++;
         $display("FAIL reload_drop: valid=%b want 0", dout_valid);
      end
      for (int j = 0; j <= 20; j++) begin
         if (j > 0) adv(1'b0, 5'd0);
         checks++;
         if (sr_wraddr !== 5'(n - 1) || sr_rdaddr !== 5'(n - 3)) begin
            errs++;
            $display("FAIL reload_addr j=%0d: got %0d/%0d want %0d/%0d",
                     j, sr_wraddr, sr_rdaddr, 5'(n - 1), 5'(n - 3));
         end
         if (j == 6) begin
            checks++;
            if (dout_valid !== 1'b0) begin
               errs++;
               $display("FAIL reload_early: valid=%b want 0", dout_valid);
            end
         end
         if (j >= 7) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== hist[n-7]) begin
               errs++;
               $display("FAIL reload_data j=%0d: got %b/%0h want 1/%0h",
                        j, dout_valid, dout, hist[n-7]);
            end
         end
      end
   endtask

   task automatic test_parity();
      int k0;
      k0 = n;
      checks++;
      if (err_count !== 8'd0) begin
         errs++;
         $display("FAIL parity_pre: count=%0d want 0", err_count);
      end
      inj = 1'b1;
      adv(1'b0, 5'd0);
      inj = 1'b0;
      adv(1'b0, 5'd0);
      checks++;
      if (dout_perr !== 1'b0) begin
         errs++;
         $display("FAIL parity_before: perr=%b want 0", dout_perr);
      end
      adv(1'b0, 5'd0);
      checks++;
      if (dout_perr !== 1'b1 || dout !== (hist[k0-4] ^ 19'h00080)) begin
         errs++;
         $display("FAIL parity_hit: got %b/%0h want 1/%0h",
                  dout_perr, dout, hist[k0-4] ^ 19'h00080);
      end
      adv(1'b0, 5'd0);
      checks++;
      if (dout_perr !== 1'b0 || dout !== hist[k0-3]) begin
         errs++;
         $display("FAIL parity_after: got %b/%0h want 0/%0h",
                  dout_perr, dout, hist[k0-3]);
      end
      checks++;
      if (err_count !== 8'd1 || err_sticky !== 1'b1) begin
         errs++;
         $display("FAIL parity_count: got %0d/%b want 1/1", err_count, err_sticky);
      end
      repeat (4) adv(1'b0, 5'd0);
      checks++;
      if (err_count !== 8'd1) begin
         errs++;
         $display("FAIL parity_hold: count=%0d want 1", err_count);
      end
   endtask

   task automatic test_saturate();
      inj = 1'b1;
      repeat (300) adv(1'b0, 5'd0);
      checks++;
      if (err_count !== 8'd255 || err_sticky !== 1'b1) begin
         errs++;
         $display("FAIL sat_reach: got %0d/%b want 255/1", err_count, err_sticky);
      end
      repeat (5) adv(1'b0, 5'd0);
      checks++;
      if (err_count !== 8'd255) begin
         errs++;
         $display("FAIL sat_hold: count=%0d want 255", err_count);
      end
      err_clear = 1'b1;
      adv(1'b0, 5'd0);
      err_clear = 1'b0;
      checks++;
      if (err_count !== 8'd1 || err_sticky !== 1'b1) begin
         errs++;
         $display("FAIL clear_vs_err: got %0d/%b want 1/1", err_count, err_sticky);
      end
      inj = 1'b0;
      repeat (8) adv(1'b0, 5'd0);
      err_clear = 1'b1;
      adv(1'b0, 5'd0);
      err_clear = 1'b0;
      checks++;
      if (err_count !== 8'd0 || err_sticky !== 1'b0) begin
         errs++;
         $display("FAIL clear_alone: got %0d/%b want 0/0", err_count, err_sticky);
      end
      repeat (4) adv(1'b0, 5'd0);
      checks++;
      if (err_count !== 8'd0) begin
         errs++;
         $display("FAIL clear_stay: count=%0d want 0", err_count);
      end
   endtask

   task automatic test_ena_toggle();
      logic [18:0] pd;
      logic        pv;
      arst = 1'b1;
      ena = 1'b0;
      @(posedge clk);
      #1;
      arst = 1'b0;
      n = 0;
      ena = 1'b1;
      delay_load = 1'b1;
      delay = 5'd8;
      @(posedge clk);
      #1;
      delay_load = 1'b0;
      checks++;
      if (sr_we !== 1'b0 || dout_valid !== 1'b0) begin
         errs++;
         $display("FAIL cfg_cycle: we=%b valid=%b want 0/0", sr_we, dout_valid);
      end
      for (int c = 1; c <= 40; c++) begin
         pd = dout;
         pv = dout_valid;
         ena = (c % 2 == 0);
         din = 19'(n);
         @(posedge clk);
         #1;
         if (ena) begin
            hist[n] = din;
            n++;
         end else begin
            checks++;
            if (dout !== pd || dout_valid !== pv) begin
               errs++;
               $display("FAIL toggle_hold c=%0d: got %0h/%b want %0h/%b",
                        c, dout, dout_valid, pd, pv);
            end
         end
         if (c == 25) begin
            checks++;
            if (dout_valid !== 1'b0) begin
               errs++;
               $display("FAIL toggle_early: valid=%b want 0", dout_valid);
            end
         end
         if (c >= 26 && ena) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== hist[n-13]) begin
               errs++;
               $display("FAIL toggle_data c=%0d: got %b/%0h want 1/%0h",
                        c, dout_valid, dout, hist[n-13]);
            end
         end
      end
      ena = 1'b1;
   endtask

   task automatic test_arst_midrun();
      repeat (3) adv(1'b0, 5'd0);
      #3;
      arst = 1'b1;
      #1;
      checks++;
      if ({dout, dout_valid, dout_perr, sr_we, sr_din, sr_rdaddr} !== 47'h0) begin
         errs++;
         $display("FAIL arst_async: got %0h want 0",
                  {dout, dout_valid, dout_perr, sr_we, sr_din, sr_rdaddr});
      end
      ena = 1'b1;
      poison = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      poison = 1'b0;
      checks++;
      if ({dout_valid, sr_we, sr_wraddr, err_count} !== 15'h0) begin
         errs++;
         $display("FAIL arst_hold: got %0h want 0",
                  {dout_valid, sr_we, sr_wraddr, err_count});
      end
      arst = 1'b0;
      n = 0;
      for (int k = 1; k <= 45; k++) begin
         adv(1'b0, 5'd0);
         if (k == 20) begin
            checks++;
            if (dout_valid !== 1'b0) begin
               errs++;
               $display("FAIL rerun_early: valid=%b want 0", dout_valid);
            end
         end
         if (k >= 21) begin
            checks++;
            if (dout_valid !== 1'b1 || dout !== hist[k-21] || dout_perr !== 1'b0) begin
               errs++;
               $display("FAIL rerun_data k=%0d: got %b/%0h/%b want 1/%0h/0",
                        k, dout_valid, dout, dout_perr, hist[k-21]);
            end
         end
      end
      checks++;
      if (err_count !== 8'd0 || err_sticky !== 1'b0) begin
         errs++;
         $display("FAIL rerun_stale: got %0d/%b want 0/0", err_count, err_sticky);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_reload();
      test_parity();
      test_saturate();
      test_ena_toggle();
      test_arst_midrun();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
